// File: rtl/nios2_proc_ram_pkg.sv
// Shared types and helpers for the dual-slave Nios II processor RAM.
package nios2_proc_ram_pkg;

  localparam int unsigned LAT_MAX = 2;

  typedef enum logic [1:0] {StIdle, StClear, StDone} clr_state_e;

  function automatic int unsigned lanes(int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/nios2_proc_ram_clear_fsm.sv
// Zero-fill sequencer: walks ptr over every word, then pulses done for one cycle.
module nios2_proc_ram_clear_fsm
  import nios2_proc_ram_pkg::*;
#(
  parameter int unsigned ADDR_W         = 14,
  parameter int unsigned DEPTH          = 10360,
  parameter bit          CLEAR_ON_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] ptr
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              boot_q;  // pending clear on the first cycle after reset release

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      boot_q  <= CLEAR_ON_RESET;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      boot_q  <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (clear_req || boot_q) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      StClear: begin
        if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = StDone;
        else                             ptr_d   = ptr_q + 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign clear_busy = (state_q == StClear);
  assign clear_done = (state_q == StDone);
  assign ptr        = ptr_q;

endmodule

// File: rtl/nios2_proc_ram_dp.sv
// Dual-slave on-chip RAM: s1 read/write for the CPU, s2 read-only for hardware
// consumers, with pipelined reads, a zero-fill engine and out-of-range detection.
module nios2_proc_ram_dp
  import nios2_proc_ram_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 14,
  parameter int unsigned DEPTH          = 10360,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b0,
  parameter string       INIT_FILE      = "nios2_proc_ram.hex"
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clken,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic                s2_read,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest,
  input  logic                clear_req,
  output logic                clear_busy,
  output logic                clear_done,
  output logic                oor_err
);

  localparam int unsigned LANES = lanes(DATA_W);

  logic              wait_all, s1_acc, oor_q;
  logic [1:0]        rd_acc, in_range, oor_hit, v1_q, zero_q;
  logic [ADDR_W-1:0] clr_ptr, a_addr;
  logic              a_we;
  logic [DATA_W-1:0] a_wdata;
  logic [LANES-1:0]  a_be;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q [2];
  logic [DATA_W-1:0] d1 [2];

  nios2_proc_ram_clear_fsm #(
    .ADDR_W         (ADDR_W),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_fsm (
    .clk        (clk),
    .reset      (reset),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .ptr        (clr_ptr)
  );

  assign wait_all       = clear_busy | ~clken | reset;
  assign s1_waitrequest = wait_all;
  assign s2_waitrequest = wait_all;

  assign in_range[0] = 32'(s1_address) < DEPTH;
  assign in_range[1] = 32'(s2_address) < DEPTH;
  assign s1_acc      = s1_chipselect & (s1_read | s1_write) & ~wait_all;
  // A simultaneous write suppresses the read half of an s1 command.
  assign rd_acc[0]   = s1_acc & ~s1_write;
  assign rd_acc[1]   = s2_read & ~wait_all;
  assign oor_hit[0]  = s1_acc & ~in_range[0];
  assign oor_hit[1]  = rd_acc[1] & ~in_range[1];

  // Port A is owned by the clear engine while it runs; s1 is stalled then.
  always_comb begin
    a_we    = s1_acc & s1_write & in_range[0];
    a_addr  = s1_address;
    a_wdata = s1_writedata;
    a_be    = s1_byteenable;
    if (clear_busy) begin
      a_we    = 1'b1;
      a_addr  = clr_ptr;
      a_wdata = '0;
      a_be    = '1;
    end
  end

  // Read-first on both ports: a same-address s2 read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (a_we) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
      end
    end
    if (rd_acc[0]) ram_q[0] <= mem[s1_address];
    if (rd_acc[1]) ram_q[1] <= mem[s2_address];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q   <= '0;
      zero_q <= '1;
      oor_q  <= 1'b0;
    end else begin
      v1_q <= rd_acc;
      for (int p = 0; p < 2; p++) begin
        if (rd_acc[p]) zero_q[p] <= ~in_range[p];
      end
      if (clear_req)     oor_q <= 1'b0;
      else if (|oor_hit) oor_q <= 1'b1;
    end
  end

  assign oor_err = oor_q;
  assign d1[0]   = zero_q[0] ? '0 : ram_q[0];
  assign d1[1]   = zero_q[1] ? '0 : ram_q[1];

  if (READ_LATENCY >= LAT_MAX) begin : g_lat2
    logic [1:0]        v2_q;
    logic [DATA_W-1:0] out_q [2];

    always_ff @(posedge clk) begin
      if (reset) begin
        v2_q     <= '0;
        out_q[0] <= '0;
        out_q[1] <= '0;
      end else begin
        v2_q <= v1_q;
        for (int p = 0; p < 2; p++) begin
          if (v1_q[p]) out_q[p] <= d1[p];
        end
      end
    end

    assign s1_readdata      = out_q[0];
    assign s2_readdata      = out_q[1];
    assign s1_readdatavalid = v2_q[0];
    assign s2_readdatavalid = v2_q[1];
  end else begin : g_lat1
    assign s1_readdata      = d1[0];
    assign s2_readdata      = d1[1];
    assign s1_readdatavalid = v1_q[0];
    assign s2_readdatavalid = v1_q[1];
  end

endmodule

// File: tb/tb_nios2_proc_ram_dp.sv
// Self-checking bench: directed vectors, clear/reset sequences and a randomized
// run against an array-based memory model.
module tb_nios2_proc_ram_dp;

  localparam int unsigned DEPTH = 10360;
  localparam int          LAT   = 1;

  logic        clk = 1'b0;
  logic        reset, clken, clear_req;
  logic [13:0] s1_address, s2_address;
  logic        s1_chipselect, s1_read, s1_write, s2_read;
  logic [3:0]  s1_byteenable;
  logic [31:0] s1_writedata, s1_readdata, s2_readdata;
  logic        s1_readdatavalid, s1_waitrequest, s2_readdatavalid, s2_waitrequest;
  logic        clear_busy, clear_done, oor_err;

  logic        c_reset, c_clken, c_clear_req, c_s1_cs, c_s1_read, c_s1_write, c_s2_read;
  logic [13:0] c_s1_address, c_s2_address;
  logic [3:0]  c_s1_be;
  logic [31:0] c_s1_wdata, c_s1_rdata, c_s2_rdata;
  logic        c_s1_rvalid, c_s1_wait, c_s2_rvalid, c_s2_wait, c_busy, c_done, c_oor;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nios2_proc_ram_dp #(.DEPTH(DEPTH), .READ_LATENCY(LAT), .CLEAR_ON_RESET(1'b0)) u_dut (
    .clk(clk), .reset(reset), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_read(s2_read), .s2_readdata(s2_readdata),
    .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest),
    .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
    .oor_err(oor_err)
  );

  nios2_proc_ram_dp #(.DEPTH(DEPTH), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)) u_cor (
    .clk(clk), .reset(c_reset), .clken(c_clken),
    .s1_address(c_s1_address), .s1_chipselect(c_s1_cs), .s1_read(c_s1_read),
    .s1_write(c_s1_write), .s1_byteenable(c_s1_be), .s1_writedata(c_s1_wdata),
    .s1_readdata(c_s1_rdata), .s1_readdatavalid(c_s1_rvalid), .s1_waitrequest(c_s1_wait),
    .s2_address(c_s2_address), .s2_read(c_s2_read), .s2_readdata(c_s2_rdata),
    .s2_readdatavalid(c_s2_rvalid), .s2_waitrequest(c_s2_wait),
    .clear_req(c_clear_req), .clear_busy(c_busy), .clear_done(c_done), .oor_err(c_oor)
  );

  typedef struct {
    bit          port2;
    bit          wr;
    logic [13:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0; s2_read = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic s1_wr(input logic [13:0] a, input logic [3:0] be, input logic [31:0] d);
    s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = a; s1_byteenable = be;
    s1_writedata = d;
    tick();
    idle();
  endtask

  task automatic wait_valid(input bit p2, output int lat);
    lat = 1;
    while (!(p2 ? s2_readdatavalid : s1_readdatavalid) && lat < 8) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_read(input bit p2, input logic [13:0] a, input logic [31:0] exp,
                         input string nm);
    int lat;
    if (p2) begin s2_read = 1'b1; s2_address = a; end
    else begin s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = a; end
    tick();
    idle();
    wait_valid(p2, lat);
    chk({nm, "_lat"}, 32'(lat), 32'(LAT));
    chk(nm, p2 ? s2_readdata : s1_readdata, exp);
    tick();
    chk({nm, "_pulse"}, 32'(p2 ? s2_readdatavalid : s1_readdatavalid), 32'd0);
  endtask

  function automatic logic [13:0] rnd_addr();
    int unsigned k = $urandom_range(15);
    if (k == 0) return 14'(DEPTH + $urandom_range(16383 - DEPTH));
    if (k < 8) return 14'($urandom_range(31));
    return 14'($urandom_range(DEPTH - 1));
  endfunction

  vec_t        vecs [8];
  logic [31:0] model [DEPTH];
  exp_t        q1 [$];
  exp_t        q2 [$];

  initial begin
    int          lat, cnt, wbad, dbad, cb, cd;
    logic [31:0] last1, last2, mask;
    bit          m_oor, acc1, acc2;

    vecs[0] = '{1'b0, 1'b1, 14'd5,     4'hF, 32'hDEADBEEF, 32'h0,        "wr5"};
    vecs[1] = '{1'b0, 1'b0, 14'd5,     4'hF, 32'h0,        32'hDEADBEEF, "s1_rd5"};
    vecs[2] = '{1'b0, 1'b1, 14'd7,     4'hF, 32'h11223344, 32'h0,        "wr7"};
    vecs[3] = '{1'b0, 1'b1, 14'd7,     4'h8, 32'hAA000000, 32'h0,        "wr7_be8"};
    vecs[4] = '{1'b1, 1'b0, 14'd7,     4'hF, 32'h0,        32'hAA223344, "s2_rd7"};
    vecs[5] = '{1'b0, 1'b1, 14'd3,     4'hF, 32'h00000012, 32'h0,        "wr3"};
    vecs[6] = '{1'b1, 1'b0, 14'd3,     4'hF, 32'h0,        32'h00000012, "s2_rd3"};
    vecs[7] = '{1'b0, 1'b0, 14'd10360, 4'hF, 32'h0,        32'h0,        "s1_rd_oor"};

    reset = 1'b1; clken = 1'b1; idle();
    s1_address = '0; s2_address = '0; s1_byteenable = '0; s1_writedata = '0;
    c_reset = 1'b1; c_clken = 1'b1; c_clear_req = 1'b0; c_s1_cs = 1'b0; c_s1_read = 1'b0;
    c_s1_write = 1'b0; c_s2_read = 1'b0; c_s1_address = '0; c_s2_address = '0;
    c_s1_be = '0; c_s1_wdata = '0;

    repeat (3) tick();
    chk("rst_s1_rdata", s1_readdata, 32'h0);
    chk("rst_s2_rdata", s2_readdata, 32'h0);
    chk("rst_valids", {30'h0, s1_readdatavalid, s2_readdatavalid}, 32'h0);
    chk("rst_clear", {30'h0, clear_busy, clear_done}, 32'h0);
    chk("rst_oor", oor_err, 1'b0);
    chk("rst_wait", {30'h0, s1_waitrequest, s2_waitrequest}, 32'h3);
    reset = 1'b0;
    tick();
    chk("run_wait", {30'h0, s1_waitrequest, s2_waitrequest}, 32'h0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) s1_wr(vecs[i].addr, vecs[i].be, vecs[i].data);
      else do_read(vecs[i].port2, vecs[i].addr, vecs[i].exp, vecs[i].name);
    end
    chk("oor_set", oor_err, 1'b1);

    s1_wr(14'd12000, 4'hF, 32'hCAFEF00D);
    do_read(1'b0, 14'd5, 32'hDEADBEEF, "after_oor_wr5");
    do_read(1'b0, 14'd7, 32'hAA223344, "after_oor_wr7");

    // Same-cycle s1 write and s2 read to one address: s2 sees the old word.
    s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 14'd3; s1_byteenable = 4'hF;
    s1_writedata = 32'h55; s2_read = 1'b1; s2_address = 14'd3;
    tick();
    idle();
    wait_valid(1'b1, lat);
    chk("coll_lat", 32'(lat), 32'(LAT));
    chk("coll_old", s2_readdata, 32'h12);
    tick();
    do_read(1'b1, 14'd3, 32'h55, "coll_new");

    // Read and write together: write wins, no read data.
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_write = 1'b1; s1_address = 14'd9;
    s1_byteenable = 4'hF; s1_writedata = 32'h99;
    tick();
    idle();
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (s1_readdatavalid) cnt++;
      tick();
    end
    chk("rw_no_valid", 32'(cnt), 32'd0);
    do_read(1'b0, 14'd9, 32'h99, "rw_wrote");

    // clken low blocks new commands but not ones already in flight.
    clken = 1'b0; s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = 14'd5;
    #1;
    chk("clken_wait", s1_waitrequest, 1'b1);
    tick();
    idle();
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (s1_readdatavalid) cnt++;
      tick();
    end
    chk("clken_blocked", 32'(cnt), 32'd0);
    clken = 1'b1; s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = 14'd7;
    tick();
    idle();
    clken = 1'b0;
    wait_valid(1'b0, lat);
    chk("inflight_data", s1_readdata, 32'hAA223344);
    tick();
    clken = 1'b1;

    // Clear request together with an s1 read: the read still gets pre-clear data.
    clear_req = 1'b1; s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = 14'd5;
    tick();
    idle();
    chk("preclear_valid", s1_readdatavalid, 1'b1);
    chk("preclear_data", s1_readdata, 32'hDEADBEEF);
    chk("oor_cleared", oor_err, 1'b0);
    cnt = 0; wbad = 0; dbad = 0;
    while (clear_busy && cnt < int'(DEPTH) + 100) begin
      cnt++;
      if (!s1_waitrequest || !s2_waitrequest) wbad++;
      if (clear_done) dbad++;
      tick();
    end
    chk("clear_cycles", 32'(cnt), 32'(DEPTH));
    chk("clear_wait", 32'(wbad), 32'd0);
    chk("clear_done_early", 32'(dbad), 32'd0);
    chk("clear_done", clear_done, 1'b1);
    tick();
    chk("clear_done_pulse", {30'h0, clear_done, clear_busy}, 32'h0);
    do_read(1'b0, 14'd0, 32'h0, "cleared0");
    do_read(1'b1, 14'd5, 32'h0, "cleared5");
    do_read(1'b0, 14'(DEPTH - 1), 32'h0, "cleared_last");

    // Randomized run against the array model (memory is all zero here).
    for (int a = 0; a < int'(DEPTH); a++) model[a] = '0;
    last1 = '0; last2 = '0; m_oor = 1'b0;
    for (int c = 0; c < 1504; c++) begin
      if (q1.size() > 0 && q1[0].due == c) begin
        chk("rnd_s1_valid", s1_readdatavalid, 1'b1);
        chk("rnd_s1_data", s1_readdata, q1[0].data);
        last1 = q1[0].data;
        void'(q1.pop_front());
      end else begin
        chk("rnd_s1_valid", s1_readdatavalid, 1'b0);
        chk("rnd_s1_hold", s1_readdata, last1);
      end
      if (q2.size() > 0 && q2[0].due == c) begin
        chk("rnd_s2_valid", s2_readdatavalid, 1'b1);
        chk("rnd_s2_data", s2_readdata, q2[0].data);
        last2 = q2[0].data;
        void'(q2.pop_front());
      end else begin
        chk("rnd_s2_valid", s2_readdatavalid, 1'b0);
        chk("rnd_s2_hold", s2_readdata, last2);
      end
      chk("rnd_oor", oor_err, m_oor);

      if (c < 1500) begin
        clken = $urandom_range(9) != 0;
        s1_chipselect = $urandom_range(3) != 0;
        s1_read = 1'($urandom_range(1));
        s1_write = $urandom_range(2) == 0;
        s1_address = rnd_addr();
        s1_byteenable = 4'($urandom);
        s1_writedata = $urandom;
        s2_read = 1'($urandom_range(1));
        s2_address = ($urandom_range(3) == 0) ? s1_address : rnd_addr();
      end else begin
        idle();
        clken = 1'b1;
      end

      acc1 = s1_chipselect && (s1_read || s1_write) && clken;
      acc2 = s2_read && clken;
      if (acc1 && !s1_write)
        q1.push_back('{c + LAT, (s1_address < DEPTH) ? model[s1_address] : 32'h0});
      if (acc2)
        q2.push_back('{c + LAT, (s2_address < DEPTH) ? model[s2_address] : 32'h0});
      if ((acc1 && s1_address >= DEPTH) || (acc2 && s2_address >= DEPTH)) m_oor = 1'b1;
      if (acc1 && s1_write && s1_address < DEPTH) begin
        mask = {{8{s1_byteenable[3]}}, {8{s1_byteenable[2]}},
                {8{s1_byteenable[1]}}, {8{s1_byteenable[0]}}};
        model[s1_address] = (model[s1_address] & ~mask) | (s1_writedata & mask);
      end
      tick();
    end
    chk("rnd_q1_drained", 32'(q1.size()), 32'd0);
    chk("rnd_q2_drained", 32'(q2.size()), 32'd0);

    // Clear-on-reset instance: interrupt its boot clear at ptr 100, then it restarts.
    chk("cor_rst_rdata", c_s2_rdata, 32'h0);
    chk("cor_rst_busy", c_busy, 1'b0);
    c_reset = 1'b0;
    tick();
    chk("cor_boot_busy", c_busy, 1'b1);
    repeat (100) tick();
    chk("cor_busy_at100", c_busy, 1'b1);
    c_reset = 1'b1;
    tick();
    chk("cor_rst_mid", {29'h0, c_busy, c_done, c_s1_wait}, 32'h1);
    tick();
    c_reset = 1'b0;
    tick();
    cb = 0; cd = 0;
    for (int i = 0; i < int'(DEPTH) + 10; i++) begin
      if (c_busy) cb++;
      if (c_done) cd++;
      tick();
    end
    chk("cor_restart_cycles", 32'(cb), 32'(DEPTH));
    chk("cor_done_once", 32'(cd), 32'd1);
    c_s2_read = 1'b1; c_s2_address = 14'(DEPTH - 1);
    tick();
    c_s2_read = 1'b0;
    lat = 1;
    while (!c_s2_rvalid && lat < 8) begin
      tick();
      lat++;
    end
    chk("cor_lat2", 32'(lat), 32'd2);
    chk("cor_rd_last", c_s2_rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
